// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM states, widths
// and requester port indices.
package mul_pkg;

    localparam int OPND_W = 32;
    localparam int PROD_W = 64;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mul_arbiter_if.sv
// Bundle of requester handshakes and multiplier-side signals around mul_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mul_arbiter_if;
    import mul_pkg::*;

    logic                req0;
    logic [0:OPND_W-1]   a0;
    logic [0:OPND_W-1]   b0;
    logic                req1;
    logic [0:OPND_W-1]   a1;
    logic [0:OPND_W-1]   b1;
    logic                gnt0;
    logic                gnt1;
    logic                rsp_valid0;
    logic                rsp_valid1;
    logic [0:PROD_W-1]   rsp_data;
    logic                err;
    logic                busy;
    logic                mul_start;
    logic [0:OPND_W-1]   mul_a;
    logic [0:OPND_W-1]   mul_b;
    logic                mul_done;
    logic [0:PROD_W-1]   mul_result;

    modport slave (
        input  req0, a0, b0, req1, a1, b1, mul_done, mul_result,
        output gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_data, err, busy,
               mul_start, mul_a, mul_b
    );

    modport master (
        output req0, a0, b0, req1, a1, b1, mul_done, mul_result,
        input  gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_data, err, busy,
               mul_start, mul_a, mul_b
    );

endinterface

// File: rtl/mul_rr_arb.sv
// Two-input round-robin arbiter, purely combinational; the pointer register
// lives in the parent so it only advances on an actual grant.
module mul_rr_arb
    import mul_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       valid
);

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = (ptr == PORT1) ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

    assign valid = |req;

endmodule

// File: rtl/mul_arbiter.sv
// Shares one multi-cycle multiplier between the pipeline MULT stage (port 0)
// and the auxiliary requester (port 1), with round-robin and timeout abort.
module mul_arbiter
    import mul_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input logic          clk,
    input logic          reset,
    mul_arbiter_if.slave bus
);

    state_t              state;
    logic                ptr;
    logic                owner;
    logic [CNT_W-1:0]    cnt;
    logic [1:0]          win;
    logic                win_valid;

    logic                gnt0;
    logic                gnt1;
    logic                rsp_valid0;
    logic                rsp_valid1;
    logic                err;
    logic                mul_start;
    logic [0:OPND_W-1]   mul_a;
    logic [0:OPND_W-1]   mul_b;
    logic [0:PROD_W-1]   rsp_data;

    mul_rr_arb u_arb (
        .req   ({bus.req1, bus.req0}),
        .ptr   (ptr),
        .grant (win),
        .valid (win_valid)
    );

    // Responses are raised on the WAIT->RESP edge so they are visible while
    // in RESP, one cycle after mul_done is sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= PORT0;
            owner      <= PORT0;
            cnt        <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            err        <= 1'b0;
            mul_start  <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            rsp_data   <= '0;
        end else begin
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            err        <= 1'b0;
            mul_start  <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        gnt0  <= win[PORT0];
                        gnt1  <= win[PORT1];
                        owner <= win[PORT1];
                        // Pointer moves to the port that did not just win.
                        ptr   <= win[PORT0];
                        mul_a <= win[PORT1] ? bus.a1 : bus.a0;
                        mul_b <= win[PORT1] ? bus.b1 : bus.b0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    mul_start <= 1'b1;
                    cnt       <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (bus.mul_done) begin
                        rsp_data   <= bus.mul_result;
                        rsp_valid0 <= (owner == PORT0);
                        rsp_valid1 <= (owner == PORT1);
                        state      <= RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_data   <= '0;
                        err        <= 1'b1;
                        rsp_valid0 <= (owner == PORT0);
                        rsp_valid1 <= (owner == PORT1);
                        state      <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0       = gnt0;
    assign bus.gnt1       = gnt1;
    assign bus.rsp_valid0 = rsp_valid0;
    assign bus.rsp_valid1 = rsp_valid1;
    assign bus.rsp_data   = rsp_data;
    assign bus.err        = err;
    assign bus.busy       = (state != IDLE);
    assign bus.mul_start  = mul_start;
    assign bus.mul_a      = mul_a;
    assign bus.mul_b      = mul_b;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: transaction-level reference model of
// round-robin choice, response timing and product value, with random traffic.
module tb_mul_arbiter;
    import mul_pkg::*;

    localparam int TMO = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mul_arbiter_if bus();

    mul_arbiter #(.TIMEOUT(TMO), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checkCount = 0;
    int failCount  = 0;
    bit refPtr     = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ctrl"}, {bus.gnt0, bus.gnt1, bus.rsp_valid0, bus.rsp_valid1,
                                     bus.err, bus.busy, bus.mul_start}, 64'd0);
        checkOutput({tag, "_mul_ab"}, {bus.mul_a, bus.mul_b}, 64'd0);
        checkOutput({tag, "_rsp_data"}, bus.rsp_data, 64'd0);
    endtask

    task automatic doReset();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.mul_done = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        refPtr = 1'b0;
    endtask

    // One complete operation. doneDelay is the cycle offset from the mul_start
    // cycle at which the multiplier model raises done; a value outside 0..TMO-1
    // means the multiplier never answers in time.
    task automatic applyStimulus(input bit r0, input bit r1,
                                 input logic [31:0] a0v, input logic [31:0] b0v,
                                 input logic [31:0] a1v, input logic [31:0] b1v,
                                 input int doneDelay, input bit dropLoser);
        bit          w;
        bit          expErr;
        int          rspAt;
        int          spurious;
        logic [31:0] wa;
        logic [31:0] wb;
        logic [63:0] prod;
        logic [63:0] expData;

        bus.req0 = r0;
        bus.req1 = r1;
        bus.a0 = a0v;
        bus.b0 = b0v;
        bus.a1 = a1v;
        bus.b1 = b1v;

        w       = (r0 && r1) ? refPtr : r1;
        wa      = w ? a1v : a0v;
        wb      = w ? b1v : b0v;
        prod    = {32'd0, wa} * {32'd0, wb};
        expErr  = (doneDelay < 0) || (doneDelay >= TMO);
        rspAt   = expErr ? TMO - 1 : doneDelay;
        expData = expErr ? 64'd0 : prod;

        step();
        checkOutput("gnt0", bus.gnt0, 64'(!w));
        checkOutput("gnt1", bus.gnt1, 64'(w));
        checkOutput("busy_at_gnt", bus.busy, 64'd1);
        checkOutput("start_not_with_gnt", bus.mul_start, 64'd0);
        refPtr = !w;
        if (w) bus.req1 = 1'b0;
        else   bus.req0 = 1'b0;
        if (dropLoser) begin
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
        end

        step();
        checkOutput("mul_start", bus.mul_start, 64'd1);
        checkOutput("mul_a", bus.mul_a, 64'(wa));
        checkOutput("mul_b", bus.mul_b, 64'(wb));
        checkOutput("gnt_one_cycle", {bus.gnt0, bus.gnt1}, 64'd0);

        spurious = 0;
        for (int k = 0; k <= rspAt; k++) begin
            bus.mul_done   = (k == doneDelay);
            bus.mul_result = bus.mul_done ? prod : {$urandom, $urandom};
            step();
            if (k < rspAt) begin
                if (bus.rsp_valid0 || bus.rsp_valid1 || bus.err || bus.mul_start) spurious++;
            end
        end
        bus.mul_done   = 1'b0;
        bus.mul_result = {$urandom, $urandom};
        checkOutput("no_early_rsp", 64'(spurious), 64'd0);
        checkOutput("rsp_valid0", bus.rsp_valid0, 64'(!w));
        checkOutput("rsp_valid1", bus.rsp_valid1, 64'(w));
        checkOutput("err", bus.err, 64'(expErr));
        checkOutput("rsp_data", bus.rsp_data, expData);
        checkOutput("busy_at_rsp", bus.busy, 64'd1);

        step();
        checkOutput("idle_busy", bus.busy, 64'd0);
        checkOutput("idle_pulses", {bus.rsp_valid0, bus.rsp_valid1, bus.err}, 64'd0);
        checkOutput("rsp_data_held", bus.rsp_data, expData);
    endtask

    initial begin
        int   quiet;
        bit   r0;
        bit   r1;

        bus.a0 = '0;
        bus.b0 = '0;
        bus.a1 = '0;
        bus.b1 = '0;
        bus.mul_result = '0;
        doReset();
        checkAllZero("reset");

        // Single request on port 0, nominal 4-cycle multiplier.
        applyStimulus(1, 0, 32'h3, 32'h5, 32'h0, 32'h0, 4, 0);

        // Both ports requesting after reset, then alternation while both held.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 32'h11 + i, 32'h7, 32'h100 + i, 32'h9, 4, 0);
        end

        // Maximum operands on port 1.
        applyStimulus(0, 1, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 0);

        // Multiplier never answers.
        applyStimulus(1, 0, 32'h1234, 32'h5678, 32'h0, 32'h0, -1, 0);

        // Reset in the middle of WAIT, then a late done that must be ignored.
        bus.req0 = 1'b1;
        bus.a0 = 32'hDEAD;
        bus.b0 = 32'hBEEF;
        step();
        bus.req0 = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        refPtr = 1'b0;
        checkAllZero("midop_reset");
        bus.mul_done = 1'b1;
        bus.mul_result = 64'hDEAD_0000_BEEF;
        quiet = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            bus.mul_done = (i == 0);
            if (bus.rsp_valid0 || bus.rsp_valid1 || bus.busy || bus.err) quiet++;
        end
        bus.mul_done = 1'b0;
        checkOutput("aborted_no_rsp", 64'(quiet), 64'd0);
        checkOutput("aborted_rsp_data", bus.rsp_data, 64'd0);
        applyStimulus(1, 0, 32'h0000_1000, 32'h0000_0010, 32'h0, 32'h0, 3, 0);

        // Port 1 withdraws in the same cycle port 0 is granted.
        doReset();
        applyStimulus(1, 1, 32'h6, 32'h7, 32'h8, 32'h9, 4, 1);
        quiet = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.gnt0 || bus.gnt1 || bus.rsp_valid1 || bus.busy) quiet++;
        end
        checkOutput("withdrawn_not_served", 64'(quiet), 64'd0);

        // Random traffic, including late/missing done.
        for (int i = 0; i < 30; i++) begin
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1'b1;
            applyStimulus(r0, r1, $urandom, $urandom, $urandom, $urandom,
                          int'($urandom_range(1, 18)), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
